mmu_feed_scheduler: RTL and testbench

//   Sequences one 2x2 matrix multiply on the systolic MMU once both operand banks are loaded.
//   On start it performs these steps in order:
//     - clears the PE accumulators;
//     - reads A (weights) and B (inputs) from the operand memory over four read ports;
//     - feeds the array with diagonal skew, then waits for it to drain;
//     - captures the four results and streams them out over a valid/ready port.

---
 rtl/tpu_pkg.sv | 36 +++
 rtl/feed_skew_gen.sv | 46 ++++
 rtl/mmu_feed_scheduler.sv | 154 +++++++++++++++
 tb/tb_mmu_feed_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the MMU feed path: default widths, scheduler state
// encoding, result index constants and the diagonal-skew lane mapping.
package tpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_FEED    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_OUTPUT  = 3'd5;

  localparam logic [1:0] C00 = 2'd0;
  localparam logic [1:0] C01 = 2'd1;
  localparam logic [1:0] C10 = 2'd2;
  localparam logic [1:0] C11 = 2'd3;

  localparam logic [1:0] FEED_LAST = 2'd2;
  // Output index value meaning "all four results accepted"
  localparam logic [2:0] IDX_FIN   = 3'd4;

  // Returns {valid, addr} for one lane at feed step `step`. k = step - lane is the
  // inner-product index; A is row-major (r*2+k), B is (k*2+c).
  function automatic logic [2:0] skew_lane(input logic [1:0] step, input logic lane,
                                           input logic is_b);
    logic [1:0] k;
    logic       ok;
    k  = step - {1'b0, lane};
    ok = (step >= {1'b0, lane}) && (k <= 2'd1);
    if (!ok) return 3'b000;
    return is_b ? {1'b1, k[0], lane} : {1'b1, lane, k[0]};
  endfunction

endpackage

// File: rtl/feed_skew_gen.sv
// Maps a feed step to the four operand-memory read addresses and registers the
// per-lane valid bits so they line up with read data returning one cycle later.
module feed_skew_gen
  import tpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_en_i,
  input  logic [1:0] issue_step_i,
  output logic [1:0] addr_a0_o,
  output logic [1:0] addr_a1_o,
  output logic [1:0] addr_b0_o,
  output logic [1:0] addr_b1_o,
  output logic [3:0] lane_vld_o   // {b1, b0, a1, a0}
);

  logic [2:0] la0, la1, lb0, lb1;
  logic [3:0] lane_vld_q, lane_vld_d;

  always_comb begin
    la0 = '0;
    la1 = '0;
    lb0 = '0;
    lb1 = '0;
    if (issue_en_i) begin
      la0 = skew_lane(issue_step_i, 1'b0, 1'b0);
      la1 = skew_lane(issue_step_i, 1'b1, 1'b0);
      lb0 = skew_lane(issue_step_i, 1'b0, 1'b1);
      lb1 = skew_lane(issue_step_i, 1'b1, 1'b1);
    end
    lane_vld_d = {lb1[2], lb0[2], la1[2], la0[2]};
  end

  assign addr_a0_o = la0[1:0];
  assign addr_a1_o = la1[1:0];
  assign addr_b0_o = lb0[1:0];
  assign addr_b1_o = lb1[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_vld_q <= '0;
    else        lane_vld_q <= lane_vld_d;
  end

  assign lane_vld_o = lane_vld_q;

endmodule

// File: rtl/mmu_feed_scheduler.sv
// Sequences one 2x2 systolic multiply: clear, skewed feed, drain, capture, stream out.
// Optional stall counter output is built when FEED_SCHED_PERF_EN is defined.
module mmu_feed_scheduler
  import tpu_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [1:0]         rd_addr_a0,
  output logic [1:0]         rd_addr_a1,
  output logic [1:0]         rd_addr_b0,
  output logic [1:0]         rd_addr_b1,
  input  logic [DATA_W-1:0]  rd_data_a0,
  input  logic [DATA_W-1:0]  rd_data_a1,
  input  logic [DATA_W-1:0]  rd_data_b0,
  input  logic [DATA_W-1:0]  rd_data_b1,
  output logic               mmu_clear,
  output logic               mmu_en,
  output logic [DATA_W-1:0]  a_row0,
  output logic [DATA_W-1:0]  a_row1,
  output logic [DATA_W-1:0]  b_col0,
  output logic [DATA_W-1:0]  b_col1,
  input  logic [4*ACC_W-1:0] mmu_res,
  output logic [ACC_W-1:0]   res_data,
  output logic [1:0]         res_idx,
  output logic               res_valid,
  input  logic               res_ready,
`ifdef FEED_SCHED_PERF_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic [2:0]         state_dbg
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       drain_q, drain_d;
  logic [2:0]       idx_q, idx_d;
  logic [ACC_W-1:0] res_q [4];
  logic [3:0]       lane_vld;
  logic             issue_en;
  logic [1:0]       issue_step;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_FEED;
        step_d  = 2'd0;
      end
      ST_FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = ST_DRAIN;
          drain_d = 8'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_CAPTURE;
        else                       drain_d = drain_q + 8'd1;
      end
      ST_CAPTURE: begin
        state_d = ST_OUTPUT;
        idx_d   = 3'd0;
      end
      ST_OUTPUT: begin
        if (idx_q == IDX_FIN) state_d = ST_IDLE;
        else if (res_ready)   idx_d   = idx_q + 3'd1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      drain_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else if (state_q == ST_CAPTURE) begin
      for (int i = 0; i < 4; i++) res_q[i] <= mmu_res[i*ACC_W +: ACC_W];
    end
  end

  // Addresses for step 0 go out in CLEAR; each FEED step issues the next one.
  assign issue_en   = (state_q == ST_CLEAR) || ((state_q == ST_FEED) && (step_q != FEED_LAST));
  assign issue_step = (state_q == ST_CLEAR) ? 2'd0 : step_q + 2'd1;

  feed_skew_gen u_skew (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_en_i   (issue_en),
    .issue_step_i (issue_step),
    .addr_a0_o    (rd_addr_a0),
    .addr_a1_o    (rd_addr_a1),
    .addr_b0_o    (rd_addr_b0),
    .addr_b1_o    (rd_addr_b1),
    .lane_vld_o   (lane_vld)
  );

  assign a_row0 = lane_vld[0] ? rd_data_a0 : '0;
  assign a_row1 = lane_vld[1] ? rd_data_a1 : '0;
  assign b_col0 = lane_vld[2] ? rd_data_b0 : '0;
  assign b_col1 = lane_vld[3] ? rd_data_b1 : '0;

  assign busy      = (state_q != ST_IDLE);
  assign mmu_clear = (state_q == ST_CLEAR);
  assign mmu_en    = (state_q == ST_FEED) || (state_q == ST_DRAIN);

  // Result port: a beat transfers on a rising edge where res_valid && res_ready;
  // while valid && !ready, res_valid/res_data/res_idx hold and the index stays put.
  assign res_valid = (state_q == ST_OUTPUT) && (idx_q != IDX_FIN);
  assign res_idx   = res_valid ? idx_q[1:0] : 2'd0;
  assign res_data  = res_valid ? res_q[idx_q[1:0]] : '0;
  assign done      = (state_q == ST_OUTPUT) && (idx_q == IDX_FIN);
  assign state_dbg = state_q;

`ifdef FEED_SCHED_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_q <= '0;
    else if ((state_q == ST_IDLE) && start)    stall_q <= '0;
    else if (res_valid && !res_ready && (stall_q != 16'hFFFF))
                                               stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mmu_feed_scheduler.sv
// Directed bench for mmu_feed_scheduler with an operand memory and a 2x2 PE array model.
module tb_mmu_feed_scheduler;
  import tpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mmu_clear, mmu_en, res_valid;
  logic          res_ready = 1'b1;
  logic [1:0]    rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1, res_idx;
  logic [DW-1:0] rd_data_a0 = '0, rd_data_a1 = '0, rd_data_b0 = '0, rd_data_b1 = '0;
  logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
  logic [4*AW-1:0] mmu_res;
  logic [AW-1:0] res_data;
  logic [2:0]    state_dbg;
`ifdef FEED_SCHED_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] mem_a [4];
  logic [DW-1:0] mem_b [4];
  logic [AW-1:0] acc [4];
  logic [DW-1:0] pa00, pa10, pb00, pb01;

  mmu_feed_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr_a0(rd_addr_a0), .rd_addr_a1(rd_addr_a1),
    .rd_addr_b0(rd_addr_b0), .rd_addr_b1(rd_addr_b1),
    .rd_data_a0(rd_data_a0), .rd_data_a1(rd_data_a1),
    .rd_data_b0(rd_data_b0), .rd_data_b1(rd_data_b1),
    .mmu_clear(mmu_clear), .mmu_en(mmu_en),
    .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
    .mmu_res(mmu_res), .res_data(res_data), .res_idx(res_idx),
    .res_valid(res_valid), .res_ready(res_ready),
`ifdef FEED_SCHED_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Operand memory: one-cycle read latency
  always @(posedge clk) begin
    rd_data_a0 <= mem_a[rd_addr_a0];
    rd_data_a1 <= mem_a[rd_addr_a1];
    rd_data_b0 <= mem_b[rd_addr_b0];
    rd_data_b1 <= mem_b[rd_addr_b1];
  end

  // 2x2 output-stationary PE array: A flows right, B flows down
  always @(posedge clk) begin
    if (mmu_clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      pa00 <= '0; pa10 <= '0; pb00 <= '0; pb01 <= '0;
    end else if (mmu_en) begin
      acc[0] <= acc[0] + AW'(a_row0) * AW'(b_col0);
      acc[1] <= acc[1] + AW'(pa00)   * AW'(b_col1);
      acc[2] <= acc[2] + AW'(a_row1) * AW'(pb00);
      acc[3] <= acc[3] + AW'(pa10)   * AW'(pb01);
      pa00 <= a_row0; pa10 <= a_row1; pb00 <= b_col0; pb01 <= b_col1;
    end
  end
  assign mmu_res = {acc[3], acc[2], acc[1], acc[0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] dot(input int p, input int q, input int r, input int s);
    int t;
    t = p * q + r * s;
    return t[AW-1:0];
  endfunction

  task automatic load(input int a00, input int a01, input int a10, input int a11,
                      input int b00, input int b01, input int b10, input int b11);
    mem_a[0] = DW'(a00); mem_a[1] = DW'(a01); mem_a[2] = DW'(a10); mem_a[3] = DW'(a11);
    mem_b[0] = DW'(b00); mem_b[1] = DW'(b01); mem_b[2] = DW'(b10); mem_b[3] = DW'(b11);
    exp_q.delete();
    exp_q.push_back(dot(a00, b00, a01, b10));
    exp_q.push_back(dot(a00, b01, a01, b11));
    exp_q.push_back(dot(a10, b00, a11, b10));
    exp_q.push_back(dot(a10, b01, a11, b11));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start is sampled at edge 0; returns sampling cycle 1 (CLEAR)
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_collect(input string tag, input int stall_idx, input int stall_len,
                             input int exp_done, input bit extra_start);
    int left;
    int done_cnt;
    int done_at;
    int hs;
    logic [AW-1:0] q[$];
    logic [1:0] sidx;
    left = stall_len; done_cnt = 0; done_at = -1; hs = 0;
    sidx = stall_idx[1:0];
    q = exp_q;
    res_ready = 1'b1;
    kick();
    chk({tag, "_clear"}, mmu_clear, 1);
    while (cyc < 60) begin
      if (cyc == 2) begin
        chk({tag, "_s0_a1_zero"}, a_row1, 0);
        chk({tag, "_s0_b1_zero"}, b_col1, 0);
      end
      if (cyc == 4) begin
        chk({tag, "_s2_a0_zero"}, a_row0, 0);
        chk({tag, "_s2_b0_zero"}, b_col0, 0);
      end
      start = extra_start && (cyc == 5 || cyc == 10);
      if (res_valid && res_idx == sidx && left > 0) begin
        res_ready = 1'b0;
        left--;
        chk({tag, "_hold_idx"}, res_idx, sidx);
        if (q.size() > 0) chk({tag, "_hold_data"}, res_data, q[0]);
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk({tag, "_extra_beat"}, hs, 4);
        else begin
          chk({tag, "_data"}, res_data, q.pop_front());
          chk({tag, "_idx"}, res_idx, hs);
        end
        hs++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_at, exp_done);
    chk({tag, "_beats"}, hs, 4);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", mmu_clear, 0);
    chk("rst_en", mmu_en, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_a_row0", a_row0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: cycle-exact walk through one multiply
    load(1, 2, 3, 4, 5, 6, 7, 8);
    kick();
    chk("t1_c1_clear", mmu_clear, 1);
    chk("t1_c1_en", mmu_en, 0);
    chk("t1_c1_state", state_dbg, ST_CLEAR);
    tick();
    chk("t1_c2_a0", a_row0, 1); chk("t1_c2_a1", a_row1, 0);
    chk("t1_c2_b0", b_col0, 5); chk("t1_c2_b1", b_col1, 0);
    chk("t1_c2_en", mmu_en, 1); chk("t1_c2_clear", mmu_clear, 0);
    chk("t1_c2_addr_a1", rd_addr_a1, 2); chk("t1_c2_addr_b0", rd_addr_b0, 2);
    tick();
    chk("t1_c3_a0", a_row0, 2); chk("t1_c3_a1", a_row1, 3);
    chk("t1_c3_b0", b_col0, 7); chk("t1_c3_b1", b_col1, 6);
    chk("t1_c3_addr_a0", rd_addr_a0, 0); chk("t1_c3_addr_b1", rd_addr_b1, 3);
    tick();
    chk("t1_c4_a0", a_row0, 0); chk("t1_c4_a1", a_row1, 4);
    chk("t1_c4_b0", b_col0, 0); chk("t1_c4_b1", b_col1, 8);
    tick();
    chk("t1_c5_en", mmu_en, 1); chk("t1_c5_a1", a_row1, 0); chk("t1_c5_b1", b_col1, 0);
    tick(); tick();
    chk("t1_c7_en", mmu_en, 1);
    tick();
    chk("t1_c8_en", mmu_en, 0); chk("t1_c8_valid", res_valid, 0); chk("t1_c8_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", res_valid, 1);
      chk("t1_idx", res_idx, i);
      chk("t1_data", res_data, exp_q[i]);
    end
    chk("t1_c12_data_c11", res_data, 50);
    tick();
    chk("t1_c13_done", done, 1); chk("t1_c13_valid", res_valid, 0); chk("t1_c13_busy", busy, 1);
    tick();
    chk("t1_c14_busy", busy, 0); chk("t1_c14_done", done, 0);

    // Test 2: consumer stalls three cycles on idx 1
    run_collect("t2", 1, 3, 16, 1'b0);
`ifdef FEED_SCHED_PERF_EN
    chk("t2_stall_cnt", stall_cnt, 3);
`endif

    // Test 3: start pulses during a run are ignored
    load(2, 0, 1, 3, 4, 1, 5, 2);
    run_collect("t3", -1, 0, 13, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_queue", busy, 0);
    end

    // Test 4: reset during DRAIN aborts; restart recomputes from a fresh clear
    load(1, 2, 3, 4, 5, 6, 7, 8);
    kick();
    repeat (5) tick();
    chk("t4_c6_drain", state_dbg, ST_DRAIN);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_en", mmu_en, 0);
    chk("t4_rst_state", state_dbg, ST_IDLE);
    chk("t4_rst_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_collect("t4", -1, 0, 13, 1'b0);

    // Test 5: full-scale operands, accumulator wraps at ACC_W
    load(255, 255, 255, 255, 255, 255, 255, 255);
    chk("t5_model_c00", exp_q[0], 16'hFC02);
    run_collect("t5", -1, 0, 13, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
